alarm_clock_param: RTL and testbench
====================================

# alarm_clock_param

Parametrised alarm clock with an internal one-second prescaler, loadable time, and a registered alarm setpoint. The alarm engine is a three-state machine: ARMED, RINGING, SNOOZED. It adds snooze, acknowledge, ring timeout and a sticky missed-alarm flag. It sits between the system clock domain and the display/annunciator logic and replaces the fixed-width level-compare alarm clock.

## Interface
- TICK_DIV, 4: clk cycles per second tick (≥1).
- SEC_MAX, 15: last seconds value before wrap.
- MIN_MAX, 3: last minutes value before wrap.
- HR_MAX, 3: last hours value before wrap.
- SEC_W, 4 / MIN_W, 2 / HR_W, 2: field widths; each must hold its MAX.
- SNOOZE_MIN, 1: snooze delay in minutes (1..MIN_MAX).
- RING_SEC, 8: seconds of ringing before auto-timeout (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- load  in  1  load preset time this cycle.
- preset_hours/preset_minutes/preset_seconds  in  HR_W/MIN_W/SEC_W  time for load.
- alarm_set  in  1  capture alarm setpoint this cycle.
- alarm_hours/alarm_minutes  in  HR_W/MIN_W  setpoint for alarm_set.
- alarm_en  in  1  level; 0 disables the alarm engine.
- snooze  in  1  single-cycle snooze request.
- ack  in  1  single-cycle dismiss request.
- hours/minutes/seconds  out  HR_W/MIN_W/SEC_W  current time.
- sec_tick  out  1  high for the one cycle in which the time fields show a tick-updated value.
- alarm  out  1  ringing indicator.
- snoozed  out  1  high in SNOOZED.
- missed  out  1  sticky; set on ring timeout.

## Operation
- Reset values: all time fields 0, prescaler 0, setpoint 00:00, snooze target 0, ring counter 0, state ARMED, and every output 0.
- Prescaler: counts 0..TICK_DIV-1. A tick occurs in the cycle it is at TICK_DIV-1; it then returns to 0.
- Tick increment: seconds+1. At SEC_MAX, seconds→0 and minutes+1. At MIN_MAX with SEC_MAX, minutes→0 and hours+1. At HR_MAX:MIN_MAX:SEC_MAX, the time goes to 0:0:0.
- load has priority over tick:
  - Fields take the preset values; any field > its MAX loads 0.
  - Prescaler clears to 0; sec_tick stays 0.
  - A load never triggers the alarm.
- alarm_set captures the setpoint. An out-of-range setpoint never matches.
- Trigger (ARMED, alarm_en=1): a tick whose new time equals alarm_hours:alarm_minutes:0 of the stored setpoint. Go to RINGING and clear the ring counter.
- RINGING:
  - alarm=1. The ring counter increments per tick.
  - ack → ARMED; also clears missed.
  - snooze (no ack) → SNOOZED; snooze target = current time + SNOOZE_MIN minutes, with hour/day wrap; seconds kept.
  - Ring counter reaches RING_SEC → ARMED, missed=1.
  - ack and snooze together: ack wins.
- SNOOZED:
  - A tick whose new time equals the snooze target → RINGING with the ring counter cleared.
  - ack → ARMED.
  - snooze is ignored.
- alarm_en=0 in any state forces ARMED and alarm=0 on the next edge. missed is unaffected.
- ack in ARMED clears missed.
- load or alarm_set during RINGING/SNOOZED does not change the state; the snooze target is not recomputed.

## Timing
- All outputs are registered.
- alarm rises on the same edge at which the time fields first show the matching value. alarm falls on the edge that samples ack/snooze/alarm_en=0, or on the tick edge at which the ring counter hits RING_SEC.
- sec_tick is coincident with the updated time. Its period is exactly TICK_DIV cycles absent load.
- load/alarm_set take effect on the next edge. The new setpoint is compared from that edge on.
- Reset mid-ring or mid-snooze: immediate return to reset values. No trigger occurs on reset release, even with setpoint 00:00.

## Test plan
- Defaults, free run 1024 cycles from reset: time passes 0:0:15→0:1:0 and 0:3:15→1:0:0, then returns to 0:0:0. sec_tick count = 256.
- alarm_set 1:2, alarm_en=1, load 1:1:15: alarm=0 after load. On the next tick, time=1:2:0 and alarm=1 on the same edge. Separately, load 1:2:0 directly: alarm stays 0.
- Ringing with no ack: alarm falls on the 8th tick after rise, missed=1. Then ack: missed=0.
- Ringing, snooze at 1:2:3: snoozed=1, alarm=0; alarm=1 again when time reaches 1:3:3. Repeat with snooze at 3:3:5: re-ring at 0:0:5.
- Ringing with ack+snooze in the same cycle: ARMED, snoozed=0, alarm=0. Ringing with alarm_en→0: alarm=0 next edge and no re-trigger.
- Reset asserted mid-SNOOZED: all outputs 0 immediately. With setpoint 0:0 and alarm_en=1 after release: no alarm until 0:0:0 is reached again by tick (after 256 ticks).

Source files
------------

// File: rtl/alarm_clock_param.sv
// Parametrised alarm clock: prescaled time-of-day counter feeding an ARMED/RINGING/SNOOZED alarm engine
// with snooze, acknowledge, ring timeout and a sticky missed flag; all outputs come from registers.
module alarm_clock_param #(
  parameter int TICK_DIV   = 4,
  parameter int SEC_MAX    = 15,
  parameter int MIN_MAX    = 3,
  parameter int HR_MAX     = 3,
  parameter int SEC_W      = 4,
  parameter int MIN_W      = 2,
  parameter int HR_W       = 2,
  parameter int SNOOZE_MIN = 1,
  parameter int RING_SEC   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [HR_W-1:0]  preset_hours,
  input  logic [MIN_W-1:0] preset_minutes,
  input  logic [SEC_W-1:0] preset_seconds,
  input  logic             alarm_set,
  input  logic [HR_W-1:0]  alarm_hours,
  input  logic [MIN_W-1:0] alarm_minutes,
  input  logic             alarm_en,
  input  logic             snooze,
  input  logic             ack,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             sec_tick,
  output logic             alarm,
  output logic             snoozed,
  output logic             missed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(RING_SEC + 1);

  typedef enum logic [1:0] {ARMED, RINGING, SNOOZED} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [HR_W-1:0]  nhr, set_hr, snz_hr, snz_hr_n;
  logic [MIN_W-1:0] nmin, set_min, snz_min, snz_min_n;
  logic [SEC_W-1:0] nsec, snz_sec;
  logic             set_ok;
  logic [RW-1:0]    ring_cnt;
  logic             alarm_hit, snooze_hit;
  logic             ring_clr, ring_inc, snz_load, missed_set, missed_clr;

  function automatic logic in_range(input int v, input int max);
    return v <= max;
  endfunction

  // A load in the same cycle swallows the tick, so loads can never trigger the alarm.
  assign tick = (presc == PW'(TICK_DIV - 1)) && !load;

  always_comb begin
    nsec = seconds + 1'b1;
    nmin = minutes;
    nhr  = hours;
    if (seconds == SEC_W'(SEC_MAX)) begin
      nsec = '0;
      nmin = minutes + 1'b1;
      if (minutes == MIN_W'(MIN_MAX)) begin
        nmin = '0;
        nhr  = (hours == HR_W'(HR_MAX)) ? '0 : hours + 1'b1;
      end
    end
  end

  always_comb begin
    int m, h;
    m = int'(minutes) + SNOOZE_MIN;
    h = int'(hours);
    if (m > MIN_MAX) begin
      m = m - (MIN_MAX + 1);
      h = (h >= HR_MAX) ? 0 : h + 1;
    end
    snz_min_n = MIN_W'(m);
    snz_hr_n  = HR_W'(h);
  end

  assign alarm_hit  = set_ok && (nsec == '0) && (nmin == set_min) && (nhr == set_hr);
  assign snooze_hit = (nsec == snz_sec) && (nmin == snz_min) && (nhr == snz_hr);

  always_comb begin
    state_n    = state;
    ring_clr   = 1'b0;
    ring_inc   = 1'b0;
    snz_load   = 1'b0;
    missed_set = 1'b0;
    missed_clr = 1'b0;
    case (state)
      ARMED: begin
        missed_clr = ack;
        if (alarm_en && tick && alarm_hit) begin
          state_n  = RINGING;
          ring_clr = 1'b1;
        end
      end
      RINGING: begin
        missed_clr = ack;
        if (!alarm_en || ack) begin
          state_n = ARMED;
        end else if (snooze) begin
          state_n  = SNOOZED;
          snz_load = 1'b1;
        end else if (tick) begin
          if (ring_cnt == RW'(RING_SEC - 1)) begin
            state_n    = ARMED;
            missed_set = 1'b1;
          end else begin
            ring_inc = 1'b1;
          end
        end
      end
      SNOOZED: begin
        if (!alarm_en || ack) begin
          state_n = ARMED;
        end else if (tick && snooze_hit) begin
          state_n  = RINGING;
          ring_clr = 1'b1;
        end
      end
      default: state_n = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARMED;
      presc    <= '0;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      sec_tick <= 1'b0;
      set_hr   <= '0;
      set_min  <= '0;
      set_ok   <= 1'b1;
      snz_hr   <= '0;
      snz_min  <= '0;
      snz_sec  <= '0;
      ring_cnt <= '0;
      missed   <= 1'b0;
    end else begin
      state    <= state_n;
      sec_tick <= tick;
      if (load) begin
        presc   <= '0;
        hours   <= in_range(int'(preset_hours), HR_MAX) ? preset_hours : '0;
        minutes <= in_range(int'(preset_minutes), MIN_MAX) ? preset_minutes : '0;
        seconds <= in_range(int'(preset_seconds), SEC_MAX) ? preset_seconds : '0;
      end else if (tick) begin
        presc   <= '0;
        hours   <= nhr;
        minutes <= nmin;
        seconds <= nsec;
      end else begin
        presc <= presc + 1'b1;
      end
      // Out-of-range setpoints are kept but flagged so they never match.
      if (alarm_set) begin
        set_hr  <= alarm_hours;
        set_min <= alarm_minutes;
        set_ok  <= in_range(int'(alarm_hours), HR_MAX) && in_range(int'(alarm_minutes), MIN_MAX);
      end
      if (snz_load) begin
        snz_hr  <= snz_hr_n;
        snz_min <= snz_min_n;
        snz_sec <= seconds;
      end
      if (ring_clr)      ring_cnt <= '0;
      else if (ring_inc) ring_cnt <= ring_cnt + 1'b1;
      if (missed_set)      missed <= 1'b1;
      else if (missed_clr) missed <= 1'b0;
    end
  end

  assign alarm   = (state == RINGING);
  assign snoozed = (state == SNOOZED);

endmodule

// File: tb/tb_alarm_clock_param.sv
// Bench for alarm_clock_param: directed scenarios plus random traffic against a time-in-seconds reference model.
`timescale 1ns/1ps
module tb_alarm_clock_param;
  localparam int TICK_DIV = 4, SEC_MAX = 15, MIN_MAX = 3, HR_MAX = 3;
  localparam int SEC_W = 4, MIN_W = 2, HR_W = 2, SNOOZE_MIN = 1, RING_SEC = 8;
  localparam int SPM = SEC_MAX + 1, MPH = MIN_MAX + 1, SPH = SPM * MPH, DAY = SPH * (HR_MAX + 1);
  localparam int TW = HR_W + MIN_W + SEC_W;

  logic clk = 1'b0, reset = 1'b0, load = 1'b0, alarm_set = 1'b0, alarm_en = 1'b0, snooze = 1'b0, ack = 1'b0;
  logic [HR_W-1:0]  preset_hours = '0, alarm_hours = '0, hours;
  logic [MIN_W-1:0] preset_minutes = '0, alarm_minutes = '0, minutes;
  logic [SEC_W-1:0] preset_seconds = '0, seconds;
  logic sec_tick, alarm, snoozed, missed;

  int total = 0, bad = 0;
  // Reference model: time as seconds-of-day, alarm engine as a few plain flags.
  int mt, mpre, melapsed, mtarget, mset_t;
  bit mtick, mring, msnz, mmissed, mset_valid;

  alarm_clock_param #(
    .TICK_DIV(TICK_DIV), .SEC_MAX(SEC_MAX), .MIN_MAX(MIN_MAX), .HR_MAX(HR_MAX),
    .SEC_W(SEC_W), .MIN_W(MIN_W), .HR_W(HR_W), .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)
  ) dut (
    .clk(clk), .reset(reset), .load(load),
    .preset_hours(preset_hours), .preset_minutes(preset_minutes), .preset_seconds(preset_seconds),
    .alarm_set(alarm_set), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_en(alarm_en), .snooze(snooze), .ack(ack),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .sec_tick(sec_tick), .alarm(alarm), .snoozed(snoozed), .missed(missed)
  );

  always #5 clk = ~clk;

  function automatic int to_t(input int h, input int m, input int s);
    if (h > HR_MAX)  h = 0;
    if (m > MIN_MAX) m = 0;
    if (s > SEC_MAX) s = 0;
    return h * SPH + m * SPM + s;
  endfunction

  function automatic logic [TW-1:0] fields(input int t);
    logic [HR_W-1:0] h; logic [MIN_W-1:0] m; logic [SEC_W-1:0] s;
    h = HR_W'(t / SPH);
    m = MIN_W'((t / SPM) % MPH);
    s = SEC_W'(t % SPM);
    return {h, m, s};
  endfunction

  function automatic logic [TW-1:0] shown();
    return {hours, minutes, seconds};
  endfunction

  task automatic model_reset();
    mt = 0; mpre = 0; melapsed = 0; mtarget = 0; mset_t = 0;
    mtick = 0; mring = 0; msnz = 0; mmissed = 0; mset_valid = 1;
  endtask

  task automatic step();
    int told; bit ring_o, snz_o;
    @(posedge clk);
    told = mt; ring_o = mring; snz_o = msnz;
    if (load) begin
      mt = to_t(int'(preset_hours), int'(preset_minutes), int'(preset_seconds));
      mpre = 0; mtick = 0;
    end else if (mpre == TICK_DIV - 1) begin
      mpre = 0; mtick = 1; mt = (mt + 1) % DAY;
    end else begin
      mpre++; mtick = 0;
    end
    if (!snz_o && ack) mmissed = 0;
    if (!alarm_en) begin
      mring = 0; msnz = 0;
    end else if (ring_o) begin
      if (ack) mring = 0;
      else if (snooze) begin
        mring = 0; msnz = 1; mtarget = (told + SNOOZE_MIN * SPM) % DAY;
      end else if (mtick) begin
        melapsed++;
        if (melapsed == RING_SEC) begin mring = 0; mmissed = 1; end
      end
    end else if (snz_o) begin
      if (ack) msnz = 0;
      else if (mtick && mt == mtarget) begin msnz = 0; mring = 1; melapsed = 0; end
    end else if (mtick && mset_valid && mt == mset_t) begin
      mring = 1; melapsed = 0;
    end
    if (alarm_set) begin
      mset_valid = (int'(alarm_hours) <= HR_MAX) && (int'(alarm_minutes) <= MIN_MAX);
      mset_t = int'(alarm_hours) * SPH + int'(alarm_minutes) * SPM;
    end
    #1;
    load = 0; alarm_set = 0; snooze = 0; ack = 0;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      step();
      if (mtick) break;
    end
  endtask

  task automatic do_load(input int h, input int m, input int s);
    preset_hours = HR_W'(h); preset_minutes = MIN_W'(m); preset_seconds = SEC_W'(s);
    load = 1; step();
  endtask

  task automatic do_set(input int h, input int m);
    alarm_hours = HR_W'(h); alarm_minutes = MIN_W'(m);
    alarm_set = 1; step();
  endtask

  task automatic arm_ring();
    alarm_en = 1; do_set(1, 2); do_load(1, 1, 15); wait_tick();
  endtask

  task automatic test_reset();
    #2 reset = 1;
    #1 model_reset();
    total++;
    if ({shown(), sec_tick, alarm, snoozed, missed} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h required=0", {shown(), sec_tick, alarm, snoozed, missed});
    end
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_free_run();
    int ticks; bit seen_a, seen_b; logic [TW-1:0] prev;
    ticks = 0; seen_a = 0; seen_b = 0; prev = '0; alarm_en = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      total++;
      if (shown() !== fields(mt) || sec_tick !== mtick) begin
        bad++; $display("FAIL free_run cyc=%0d time=%h tick=%b required time=%h tick=%b", i, shown(), sec_tick, fields(mt), mtick);
      end
      if (sec_tick === 1'b1) begin
        ticks++;
        if (prev == fields(to_t(0, 0, 15)) && shown() == fields(to_t(0, 1, 0))) seen_a = 1;
        if (prev == fields(to_t(0, 3, 15)) && shown() == fields(to_t(1, 0, 0))) seen_b = 1;
        prev = shown();
      end
    end
    total++;
    if (ticks != 256) begin bad++; $display("FAIL free_run_ticks got=%0d required=256", ticks); end
    total++;
    if (!seen_a || !seen_b) begin bad++; $display("FAIL free_run_wraps got=%b%b required=11", seen_a, seen_b); end
    total++;
    if (shown() !== '0) begin bad++; $display("FAIL free_run_day_wrap got=%h required=0", shown()); end
  endtask

  task automatic test_alarm_trigger();
    alarm_en = 1; do_set(1, 2); do_load(1, 1, 15);
    total++;
    if (shown() !== fields(to_t(1, 1, 15)) || alarm !== 1'b0 || sec_tick !== 1'b0) begin
      bad++; $display("FAIL after_load time=%h alarm=%b tick=%b required %h 0 0", shown(), alarm, sec_tick, fields(to_t(1, 1, 15)));
    end
    wait_tick();
    total++;
    if (shown() !== fields(to_t(1, 2, 0)) || alarm !== 1'b1) begin
      bad++; $display("FAIL trigger time=%h alarm=%b required %h 1", shown(), alarm, fields(to_t(1, 2, 0)));
    end
    ack = 1; step();
    total++;
    if (alarm !== 1'b0) begin bad++; $display("FAIL ack_dismiss alarm=%b required 0", alarm); end
    do_load(1, 2, 0);
    total++;
    if (alarm !== 1'b0 || shown() !== fields(to_t(1, 2, 0))) begin
      bad++; $display("FAIL load_no_trigger alarm=%b time=%h required 0 %h", alarm, shown(), fields(to_t(1, 2, 0)));
    end
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      total++;
      if (alarm !== 1'b0) begin bad++; $display("FAIL load_no_trigger_tick%0d alarm=%b required 0", k, alarm); end
    end
  endtask

  task automatic test_ring_timeout();
    arm_ring();
    total++;
    if (alarm !== 1'b1) begin bad++; $display("FAIL timeout_rise alarm=%b required 1", alarm); end
    for (int k = 1; k <= RING_SEC; k++) begin
      wait_tick();
      total++;
      if (alarm !== (k < RING_SEC)) begin
        bad++; $display("FAIL timeout_tick%0d alarm=%b required %b", k, alarm, k < RING_SEC);
      end
    end
    total++;
    if (missed !== 1'b1) begin bad++; $display("FAIL missed_set got=%b required 1", missed); end
    ack = 1; step();
    total++;
    if (missed !== 1'b0) begin bad++; $display("FAIL missed_clear got=%b required 0", missed); end
  endtask

  task automatic snooze_and_rering(input string name, input int expect_t);
    bit got;
    snooze = 1; step();
    total++;
    if (snoozed !== 1'b1 || alarm !== 1'b0) begin
      bad++; $display("FAIL %s_enter snoozed=%b alarm=%b required 1 0", name, snoozed, alarm);
    end
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (alarm === 1'b1) got = 1;
    end
    total++;
    if (!got || shown() !== fields(expect_t)) begin
      bad++; $display("FAIL %s_rering rose=%b time=%h required 1 %h", name, got, shown(), fields(expect_t));
    end
    ack = 1; step();
  endtask

  task automatic test_snooze();
    arm_ring();
    repeat (3) wait_tick();
    total++;
    if (shown() !== fields(to_t(1, 2, 3)) || alarm !== 1'b1) begin
      bad++; $display("FAIL snooze_setup time=%h alarm=%b required %h 1", shown(), alarm, fields(to_t(1, 2, 3)));
    end
    snooze_and_rering("snooze_a", to_t(1, 3, 3));
    do_set(3, 3); do_load(3, 2, 15); wait_tick();
    repeat (5) wait_tick();
    total++;
    if (shown() !== fields(to_t(3, 3, 5)) || alarm !== 1'b1) begin
      bad++; $display("FAIL snooze_wrap_setup time=%h alarm=%b required %h 1", shown(), alarm, fields(to_t(3, 3, 5)));
    end
    snooze_and_rering("snooze_wrap", to_t(0, 0, 5));
  endtask

  task automatic test_ack_priority_and_disable();
    arm_ring();
    ack = 1; snooze = 1; step();
    total++;
    if (alarm !== 1'b0 || snoozed !== 1'b0) begin
      bad++; $display("FAIL ack_over_snooze alarm=%b snoozed=%b required 0 0", alarm, snoozed);
    end
    for (int k = 0; k < 20; k++) begin
      wait_tick();
      total++;
      if (alarm !== 1'b0 || snoozed !== 1'b0) begin
        bad++; $display("FAIL ack_over_snooze_t%0d alarm=%b snoozed=%b required 0 0", k, alarm, snoozed);
      end
    end
    arm_ring();
    alarm_en = 0; step();
    total++;
    if (alarm !== 1'b0) begin bad++; $display("FAIL disable alarm=%b required 0", alarm); end
    alarm_en = 1;
    for (int k = 0; k < 20; k++) begin
      wait_tick();
      total++;
      if (alarm !== 1'b0) begin bad++; $display("FAIL disable_retrigger_t%0d alarm=%b required 0", k, alarm); end
    end
  endtask

  task automatic test_reset_mid_snooze();
    int n; bit rose;
    arm_ring();
    snooze = 1; step();
    total++;
    if (snoozed !== 1'b1) begin bad++; $display("FAIL pre_reset_snoozed got=%b required 1", snoozed); end
    #3 reset = 1;
    #1 model_reset();
    total++;
    if ({shown(), sec_tick, alarm, snoozed, missed} !== '0) begin
      bad++; $display("FAIL reset_mid_snooze got=%h required=0", {shown(), sec_tick, alarm, snoozed, missed});
    end
    @(posedge clk); #1 reset = 0; alarm_en = 1;
    n = 0; rose = 0;
    for (int i = 0; i < 300 * TICK_DIV && !rose; i++) begin
      step();
      if (mtick) n++;
      if (alarm === 1'b1) rose = 1;
    end
    total++;
    if (!rose || n != DAY || shown() !== '0) begin
      bad++; $display("FAIL midnight_alarm rose=%b ticks=%0d time=%h required 1 %0d 0", rose, n, shown(), DAY);
    end
  endtask

  task automatic test_random();
    alarm_en = 1;
    for (int i = 0; i < 4000; i++) begin
      load = ($urandom_range(0, 49) == 0);
      preset_hours = HR_W'($urandom_range(0, (1 << HR_W) - 1));
      preset_minutes = MIN_W'($urandom_range(0, (1 << MIN_W) - 1));
      preset_seconds = SEC_W'($urandom_range(0, (1 << SEC_W) - 1));
      alarm_set = ($urandom_range(0, 39) == 0);
      alarm_hours = HR_W'($urandom_range(0, (1 << HR_W) - 1));
      alarm_minutes = MIN_W'($urandom_range(0, (1 << MIN_W) - 1));
      snooze = ($urandom_range(0, 29) == 0);
      ack = ($urandom_range(0, 89) == 0);
      if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
      step();
      total++;
      if (shown() !== fields(mt) || sec_tick !== mtick || alarm !== mring || snoozed !== msnz || missed !== mmissed) begin
        bad++;
        $display("FAIL random cyc=%0d got t=%h tk=%b al=%b sn=%b mi=%b required t=%h tk=%b al=%b sn=%b mi=%b",
                 i, shown(), sec_tick, alarm, snoozed, missed, fields(mt), mtick, mring, msnz, mmissed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_alarm_trigger();
    test_ring_timeout();
    test_snooze();
    test_ack_priority_and_disable();
    test_reset_mid_snooze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
